// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one memory port, one transaction in flight.
// Optional macro ARB_RR_EN selects round-robin arbitration; default gives load/store fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [63:0] if_rsp_data,
    input  logic        ls_req_valid,
    input  logic        ls_req_wen,
    input  logic [63:0] ls_req_addr,
    input  logic [63:0] ls_req_wdata,
    input  logic [7:0]  ls_req_wmask,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [63:0] ls_rsp_data,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        err_timeout
);

    // Handshake: a request transfers in the cycle where its valid and ready are both high;
    // ready is only ever raised in IDLE, for one requester at a time.

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // wait_cnt holds the number of WAIT cycles already spent without a response.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        owner_ls;
    logic [7:0]  wait_cnt;
    logic        grant_ls;
    logic        grant_if;
    logic [63:0] rsp_word;

`ifdef ARB_RR_EN
    logic last_ls;

    always_comb begin
        grant_ls = ls_req_valid && (!if_req_valid || !last_ls);
        grant_if = if_req_valid && !grant_ls;
    end
`else
    always_comb begin
        grant_ls = ls_req_valid;
        grant_if = if_req_valid && !ls_req_valid;
    end
`endif

    assign if_req_ready = rst_n && (state == S_IDLE) && grant_if;
    assign ls_req_ready = rst_n && (state == S_IDLE) && grant_ls;
    assign rsp_word     = mem_wen ? 64'd0 : mem_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            owner_ls     <= 1'b0;
            wait_cnt     <= '0;
            mem_valid    <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            err_timeout  <= 1'b0;
`ifdef ARB_RR_EN
            last_ls      <= 1'b0;
`endif
        end else begin
            mem_valid    <= 1'b0;
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_data  <= '0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ls || grant_if) begin
                        owner_ls  <= grant_ls;
                        mem_valid <= 1'b1;
                        state     <= S_ISSUE;
`ifdef ARB_RR_EN
                        last_ls   <= grant_ls;
`endif
                        if (grant_ls) begin
                            mem_wen   <= ls_req_wen;
                            mem_addr  <= ls_req_addr;
                            mem_wdata <= ls_req_wdata;
                            mem_wmask <= ls_req_wmask;
                        end else begin
                            mem_wen   <= 1'b0;
                            mem_addr  <= if_req_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving on the final allowed cycle beats the timeout.
                    if (mem_rsp_valid) begin
                        state <= S_RESP;
                        if (owner_ls) begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= rsp_word;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= rsp_word;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= S_RESP;
                        err_timeout  <= 1'b1;
                        ls_rsp_valid <= owner_ls;
                        if_rsp_valid <= !owner_ls;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter (TIMEOUT=4) against a transaction-level reference model.
// Works with and without ARB_RR_EN defined.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_wen, ls_req_ready, ls_rsp_valid;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [7:0]  ls_req_wmask;
    logic        mem_valid, mem_wen, mem_rsp_valid, err_timeout;
    logic [63:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [7:0]  mem_wmask;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .err_timeout(err_timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    // entry layout: {ls_rsp_valid, if_rsp_valid, err_timeout, 1'b0, data}
    logic [67:0] exp_q[$];
    bit          last_ls_m = 1'b0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("one_ready", {63'd0, if_req_ready & ls_req_ready}, 68'd0);
            if (if_rsp_valid || ls_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 68'd1, 68'd0);
                end else begin
                    check("rsp_payload",
                          {ls_rsp_valid, if_rsp_valid, err_timeout, 1'b0,
                           ls_rsp_valid ? ls_rsp_data : if_rsp_data},
                          exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- reference arbitration rule ----------------
    function automatic bit pick_ls(input bit iv, input bit lv);
        if (!lv) return 1'b0;
        if (!iv) return 1'b1;
`ifdef ARB_RR_EN
        return !last_ls_m;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        ls_req_valid  = 1'b0;
        ls_req_wen    = 1'b0;
        ls_req_addr   = '0;
        ls_req_wdata  = '0;
        ls_req_wmask  = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                               mem_valid, mem_wen, err_timeout}, 68'd0);
        check({tag, "_if_data"}, if_rsp_data, 68'd0);
        check({tag, "_ls_data"}, ls_rsp_data, 68'd0);
        check({tag, "_mem_addr"}, mem_addr, 68'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 68'd0);
        check({tag, "_mem_wmask"}, mem_wmask, 68'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        check_all_zero("rst");
        drive_idle();
        repeat (2) @(negedge clk);
        exp_q.delete();
        last_ls_m = 1'b0;
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // d = WAIT cycle on which memory answers (d > TO means it never answers in time).
    task automatic run_txn(input bit iv, input bit lv, input bit wen,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input logic [63:0] mdata,
                           input int d, input bit stray, output bit got_ls);
        bit          g;
        bit          tmo;
        int          n;
        logic [63:0] if_addr, e_addr, edata;
        if_addr = (iv && lv) ? {addr[31:0], addr[63:32]} : addr;
        if_req_valid = iv;
        if_req_addr  = if_addr;
        ls_req_valid = lv;
        ls_req_wen   = wen;
        ls_req_addr  = addr;
        ls_req_wdata = wdata;
        ls_req_wmask = wmask;
        g      = pick_ls(iv, lv);
        got_ls = g;
        tmo    = (d > TO);
        edata  = (tmo || (g && wen)) ? 64'd0 : mdata;
        e_addr = g ? addr : if_addr;
        #1;
        check("if_ready", {67'd0, if_req_ready}, {67'd0, iv && !g});
        check("ls_ready", {67'd0, ls_req_ready}, {67'd0, g});
        exp_q.push_back({g, !g, tmo, 1'b0, edata});
        last_ls_m = g;

        @(negedge clk);  // ISSUE
        check("mem_valid_issue", {67'd0, mem_valid}, 68'd1);
        check("mem_wen_mask", {mem_wen, mem_wmask}, {g && wen, g ? wmask : 8'd0});
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, g ? wdata : 64'd0);
        check("ready_busy", {if_req_ready, ls_req_ready}, 68'd0);
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        mem_rsp_valid = stray;
        mem_rsp_data  = {$urandom, $urandom};

        n = tmo ? TO : d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);  // WAIT cycle k
            mem_rsp_valid = (k == d);
            mem_rsp_data  = (k == d) ? mdata : {$urandom, $urandom};
            check("wait_quiet", {mem_valid, if_rsp_valid, ls_rsp_valid, err_timeout}, 68'd0);
            check("mem_addr_hold", mem_addr, e_addr);
        end

        @(negedge clk);  // RESP
        mem_rsp_valid = stray;
        mem_rsp_data  = {$urandom, $urandom};
        check("rsp_strobe", {ls_rsp_valid, if_rsp_valid, err_timeout}, {g, !g, tmo});

        @(negedge clk);  // back in IDLE
        mem_rsp_valid = 1'b0;
        check("idle_quiet", {mem_valid, if_rsp_valid, ls_rsp_valid, err_timeout,
                             if_req_ready, ls_req_ready}, 68'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          got;
        bit   [3:0]  order;
        bit   [1:0]  r;
        logic [3:0]  exp_order;
        drive_idle();
        repeat (2) @(negedge clk);
        do_reset();

        // Both requesters valid for four arbitrations straight after reset.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF,
                    {$urandom, $urandom}, 1, 1'b0, got);
            order[i] = got;
        end
`ifdef ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        check("grant_order", {64'd0, order}, {64'd0, exp_order});

        // Directed fetch and store, then the timeout boundary on both requesters.
        run_txn(1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0413, 2, 1'b0, got);
        run_txn(1'b0, 1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h1234_5678, 2, 1'b0, got);
        run_txn(1'b1, 1'b0, 1'b0, 64'h10, 64'd0, 8'h00, 64'hAAAA, 5, 1'b0, got);
        run_txn(1'b1, 1'b0, 1'b0, 64'h20, 64'd0, 8'h00, 64'hBBBB, 4, 1'b0, got);
        run_txn(1'b0, 1'b1, 1'b0, 64'h30, 64'd0, 8'h00, 64'hCCCC, 4, 1'b1, got);
        run_txn(1'b0, 1'b1, 1'b1, 64'h40, 64'h55, 8'h81, 64'hDDDD, 9, 1'b1, got);

        for (int i = 0; i < 60; i++) begin
            r = 2'($urandom_range(1, 3));
            run_txn(r[0], r[1], 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    {$urandom, $urandom}, 8'($urandom_range(0, 255)), {$urandom, $urandom},
                    $urandom_range(1, 6), 1'($urandom_range(0, 1)), got);
        end

        // Reset in the middle of WAIT, then a stale memory response.
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h900;
        @(negedge clk);
        ls_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        last_ls_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hFFFF_0000_FFFF_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check("post_rst_quiet", {if_rsp_valid, ls_rsp_valid, err_timeout, mem_valid}, 68'd0);
        end
        run_txn(1'b1, 1'b1, 1'b1, 64'hA0, 64'h77, 8'h3C, 64'hEEEE, 3, 1'b0, got);

        check("exp_q_empty", exp_q.size(), 68'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
